// File: rtl/maple_tx_encoder.sv
// maple_tx_encoder
// Serialises bytes from a first-word-fall-through FIFO onto the two-wire
// Maple bus (SDCKA / SDCKB). A frame is: start pattern, zero or more bytes
// (17 cycles each: one load cycle plus 16 bit cycles), end pattern.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   enable     frame request, sampled only while idle
//   empty      FIFO empty flag
//   data[7:0]  FIFO head byte (valid when empty=0)
//   next       FIFO pop strobe, one cycle per consumed byte
//   busy       high whenever a frame is in progress
//   sdcka      Maple line A (idle high)
//   sdckb      Maple line B (idle high)
//   dbg_state  current FSM state, for observation only
//
// Handshake: the FIFO is popped on a rising edge where next=1; next is only
// raised in a load cycle while empty=0, and the head byte is captured on
// that same edge.
module maple_tx_encoder #(
    parameter int START_TICKS = 4,
    parameter int END_TICKS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       empty,
    input  logic [7:0] data,
    output logic       busy,
    output logic       sdcka,
    output logic       sdckb,
    output logic       next,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        START            = 3'd1,
        SEND_START_FRAME = 3'd2,
        SEND_DATA        = 3'd3,
        SEND_END_FRAME   = 3'd4
    } state_t;

    // The phase counter must reach the longest of the three phases.
    localparam int MAX_A   = (2 * START_TICKS > 16) ? 2 * START_TICKS : 16;
    localparam int MAX_CNT = (2 * END_TICKS > MAX_A) ? 2 * END_TICKS : MAX_A;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] START_LAST = CW'(2 * START_TICKS);
    localparam logic [CW-1:0] END_LAST   = CW'(2 * END_TICKS);
    localparam logic [CW-1:0] BIT_LAST   = CW'(16);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    sr_q, sr_d;

    // Next-state logic. In SEND_DATA, cnt=0 is the load cycle and 1..16 are
    // the bit cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = SEND_START_FRAME;
            end
            SEND_START_FRAME: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = SEND_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SEND_DATA: begin
                if (cnt_q == '0) begin
                    if (empty) begin
                        state_d = SEND_END_FRAME;
                    end else begin
                        sr_d  = data;
                        cnt_d = CNT_ONE;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SEND_END_FRAME: begin
                if (cnt_q == END_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sr_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    // Bit-cycle decode: pos = cnt-1 (0..15); pos[3:1] is the bit slot counted
    // from the MSB, pos[0] selects the second (clock-low) half of the bit.
    // cnt=16 wraps to pos=15 in the low four bits, which is the intended slot.
    logic [3:0] bit_pos;
    logic [2:0] bit_num;
    logic       bit_val;
    logic       second_half;
    logic       a_clocked;

    always_comb begin
        bit_pos     = cnt_q[3:0] - 4'd1;
        bit_num     = ~bit_pos[3:1];
        bit_val     = sr_q[bit_num];
        second_half = bit_pos[0];
        // Odd-numbered bits (7,5,3,1) are clocked on A with data on B.
        a_clocked   = bit_num[0];
    end

    // Line decode uses registered state only.
    always_comb begin
        sdcka = 1'b1;
        sdckb = 1'b1;
        case (state_q)
            SEND_START_FRAME: begin
                sdcka = 1'b0;
                sdckb = ~cnt_q[0];
            end
            SEND_DATA: begin
                if (cnt_q != '0) begin
                    if (a_clocked) begin
                        sdcka = ~second_half;
                        sdckb = bit_val;
                    end else begin
                        sdcka = bit_val;
                        sdckb = ~second_half;
                    end
                end
            end
            SEND_END_FRAME: begin
                sdcka = ~cnt_q[0];
                sdckb = 1'b0;
            end
            default: begin
                sdcka = 1'b1;
                sdckb = 1'b1;
            end
        endcase
    end

    // Pop strobe is suppressed while reset is asserted so that an aborted
    // frame never consumes a byte.
    assign next      = (state_q == SEND_DATA) && (cnt_q == '0) && !empty && !reset;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_maple_tx_encoder.sv
module tb_maple_tx_encoder;

    localparam int START_TICKS = 4;
    localparam int END_TICKS   = 2;
    // Expected-entry packing: {busy, sdcka, sdckb, next}
    localparam logic [3:0] IDLE_E = 4'b0110;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       empty;
    logic [7:0] data;
    logic       busy;
    logic       sdcka;
    logic       sdckb;
    logic       next;
    logic [2:0] dbg_state;

    maple_tx_encoder #(
        .START_TICKS(START_TICKS),
        .END_TICKS  (END_TICKS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .empty    (empty),
        .data     (data),
        .busy     (busy),
        .sdcka    (sdcka),
        .sdckb    (sdckb),
        .next     (next),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];
    logic [7:0] fifo_q[$];
    int         next_pos[$];
    logic [7:0] frm[0:3];
    int         checks;
    int         failures;
    int         busy_cnt;
    bit         check_en;
    bit         pop_pending;
    logic [3:0] ce;
    logic [3:0] cg;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic drive_fifo();
        empty = (fifo_q.size() == 0);
        data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // FIFO model: pops on the edge where next was seen high.
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pending = 1'b0;
        drive_fifo();
    end

    // Compare process: every cycle, DUT lines against the expected stream.
    always @(negedge clk) begin
        if (check_en) begin
            ce = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_E;
            cg = {busy, sdcka, sdckb, next};
            checks++;
            if (cg !== ce) begin
                failures++;
                $display("FAIL lines t=%0t got busy/a/b/next=%b expected=%b", $time, cg, ce);
            end
            if (busy) busy_cnt++;
            if (next) next_pos.push_back(busy_cnt);
        end
        pop_pending = next;
    end

    // ---------------- reference model ----------------
    // Builds the per-cycle line waveform of one frame from the protocol rules.
    task automatic push_frame(input int n);
        logic bv;
        exp_q.push_back(4'b1110);                     // START
        exp_q.push_back(4'b1010);                     // start cycle 0: A=0,B=1
        for (int t = 0; t < START_TICKS; t++) begin
            exp_q.push_back(4'b1000);
            exp_q.push_back(4'b1010);
        end
        for (int j = 0; j < n; j++) begin
            exp_q.push_back(4'b1111);                 // load with pop
            for (int i = 7; i >= 0; i--) begin
                bv = frm[j][i];
                if (i % 2 == 1) begin
                    exp_q.push_back({1'b1, 1'b1, bv, 1'b0});
                    exp_q.push_back({1'b1, 1'b0, bv, 1'b0});
                end else begin
                    exp_q.push_back({1'b1, bv, 1'b1, 1'b0});
                    exp_q.push_back({1'b1, bv, 1'b0, 1'b0});
                end
            end
        end
        exp_q.push_back(4'b1110);                     // load, FIFO empty
        exp_q.push_back(4'b1100);                     // end cycle 0: A=1,B=0
        for (int t = 0; t < END_TICKS; t++) begin
            exp_q.push_back(4'b1000);
            exp_q.push_back(4'b1100);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input bit rnd_en);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            step();
            guard++;
            // enable is ignored outside IDLE, so wiggle it while a frame runs
            enable = (rnd_en && exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        enable = 1'b0;
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run_frame(input int n, input bit rnd_en);
        fifo_q.delete();
        for (int j = 0; j < n; j++) fifo_q.push_back(frm[j]);
        drive_fifo();
        busy_cnt = 0;
        next_pos.delete();
        exp_q.push_back(IDLE_E);   // the cycle in which enable is sampled
        push_frame(n);
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_drain(rnd_en);
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] keep;
        int n;
        checks      = 0;
        failures    = 0;
        busy_cnt    = 0;
        check_en    = 1'b0;
        pop_pending = 1'b0;
        reset       = 1'b1;
        enable      = 1'b0;
        empty       = 1'b1;
        data        = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        check_en = 1'b1;
        repeat (3) step();          // idle lines high with enable=0

        // Single byte 0xA5
        frm[0] = 8'hA5;
        run_frame(1, 1'b0);
        chk("a5_busy_cycles", busy_cnt, 33);
        chk("a5_next_count", next_pos.size(), 1);
        if (next_pos.size() > 0) chk("a5_next_cycle", next_pos[0], 11);

        // Zero-byte frame
        run_frame(0, 1'b0);
        chk("empty_busy_cycles", busy_cnt, 16);
        chk("empty_next_count", next_pos.size(), 0);

        // 0x00 then 0xFF back to back
        frm[0] = 8'h00;
        frm[1] = 8'hFF;
        run_frame(2, 1'b0);
        chk("two_busy_cycles", busy_cnt, 50);
        chk("two_next_count", next_pos.size(), 2);
        if (next_pos.size() == 2) begin
            chk("two_next_first", next_pos[0], 11);
            chk("two_next_spacing", next_pos[1] - next_pos[0], 17);
        end

        // Reset during bit 3 of a byte
        frm[0] = 8'h3C;
        fifo_q.delete();
        fifo_q.push_back(frm[0]);
        drive_fifo();
        busy_cnt = 0;
        next_pos.delete();
        exp_q.push_back(IDLE_E);
        push_frame(1);
        enable = 1'b1;
        step();                     // START cycle (busy cycle 1)
        enable = 1'b0;
        repeat (19) step();         // busy cycle 20: first half of bit 3
        reset = 1'b1;
        keep  = exp_q[0];
        exp_q.delete();
        exp_q.push_back(keep);      // this cycle still shows bit 3, then idle
        step();
        reset = 1'b0;
        step();
        chk("rst_next_count", next_pos.size(), 1);
        chk("rst_fifo_left", fifo_q.size(), 0);
        run_frame(0, 1'b0);
        chk("rst_replay_busy", busy_cnt, 16);

        // enable held high: one frame, one idle cycle, then a new frame
        frm[0] = 8'h5A;
        fifo_q.delete();
        fifo_q.push_back(frm[0]);
        drive_fifo();
        busy_cnt = 0;
        next_pos.delete();
        exp_q.push_back(IDLE_E);
        push_frame(1);
        exp_q.push_back(IDLE_E);
        push_frame(0);
        enable = 1'b1;
        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 8 && guard < 500) begin
                step();
                guard++;
            end
        end
        enable = 1'b0;
        wait_drain(1'b0);
        repeat (3) step();
        chk("hold_busy_cycles", busy_cnt, 33 + 16);
        chk("hold_next_count", next_pos.size(), 1);

        // Randomised frames
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++) frm[j] = 8'($urandom_range(0, 255));
            run_frame(n, 1'b1);
            chk("rnd_busy_cycles", busy_cnt, 16 + 17 * n);
            chk("rnd_next_count", next_pos.size(), n);
            repeat ($urandom_range(0, 3)) step();
        end

        step();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maple_tx_encoder.md
MAPLE_TX_ENCODER -- requirements
Module: maple_tx_encoder

Interface
REQ-001 Parameter START_TICKS, default 4, number of SDCKB pulses in the start pattern.
REQ-002 Parameter END_TICKS, default 2, number of SDCKA pulses in the end pattern.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 enable  input  1  request one frame transmission; sampled only in IDLE.
REQ-006 busy  output  1  high whenever state is not IDLE.
REQ-007 sdcka  output  1  Maple line A; idle high.
REQ-008 sdckb  output  1  Maple line B; idle high.
REQ-009 empty  input  1  source FIFO empty flag.
REQ-010 data  input  8  source FIFO head byte; first-word-fall-through, valid when empty=0.
REQ-011 next  output  1  FIFO pop strobe; one cycle per consumed byte.

Function
REQ-012 States SHALL be IDLE, START, SEND_START_FRAME, SEND_DATA and SEND_END_FRAME.
REQ-013 IDLE -> START when enable=1; START -> SEND_START_FRAME after exactly 1 cycle; enable SHALL be ignored outside IDLE.
REQ-014 In IDLE and START, sdcka=1 and sdckb=1.
REQ-015 SEND_START_FRAME SHALL last 1+2*START_TICKS cycles: cycle 0 A=0,B=1; then START_TICKS repeats of (B=0 one cycle, B=1 one cycle), with A=0 throughout; then -> SEND_DATA.
REQ-016 SEND_DATA SHALL consist of load cycles and bit cycles; its first cycle is a load cycle.
REQ-017 Load cycle: A=1,B=1. If empty=0, next=1 and data is captured into the shift register at that edge, followed by 16 bit cycles. If empty=1, next=0 and the state moves to SEND_END_FRAME on the next cycle.
REQ-018 Bits SHALL be sent MSB first, 2 cycles per bit, 16 cycles per byte.
REQ-019 Bits 7,5,3,1 are clocked by A with data on B: cycle 1 A=1,B=bit; cycle 2 A=0,B=bit.
REQ-020 Bits 6,4,2,0 are clocked by B with data on A: cycle 1 A=bit,B=1; cycle 2 A=bit,B=0.
REQ-021 After bit 0's second cycle, another load cycle SHALL follow immediately; bytes stream back-to-back at 17 cycles per byte until the FIFO is empty.
REQ-022 next SHALL be combinational from the load-cycle state and empty only, and SHALL be 0 in all other cycles.
REQ-023 sdcka and sdckb SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-024 SEND_END_FRAME SHALL last 1+2*END_TICKS cycles: cycle 0 B=0,A=1; then END_TICKS repeats of (A=0, A=1), with B=0 throughout; then -> IDLE with both lines high.
REQ-025 A zero-byte frame (empty=1 at the first load cycle) SHALL still emit the start and end patterns.
REQ-026 Any undefined state encoding SHALL go to IDLE on the next cycle.

Reset
REQ-027 While reset=1 at a clock edge, the next state SHALL be IDLE with all counters and the shift register cleared; then sdcka=1, sdckb=1, busy=0, next=0.
REQ-028 Reset SHALL take priority over enable and over any in-progress frame; mid-frame reset aborts without emitting an end pattern.
REQ-029 There SHALL be no FIFO pop during or after a reset until a new frame reaches a load cycle.

Verification
REQ-030 Reset asserted 2 cycles -> A=1, B=1, busy=0, next=0; idle lines stay high with enable=0.
REQ-031 FIFO holds 0xA5, enable 1 cycle (defaults):
- busy high for exactly 33 cycles (1 START + 9 start + 17 byte + 1 empty load + 5 end);
- next pulses once, in cycle 11 of busy;
- bit data sequence B=1, A=0, B=1, A=0, B=0, A=1, B=0, A=1.
REQ-032 Empty FIFO, enable -> busy for 16 cycles, next never asserted, start and end patterns intact.
REQ-033 FIFO holds 0x00 then 0xFF -> next pulses exactly 17 cycles apart; busy=50 cycles; all data-line bits are 0 in byte 1 and 1 in byte 2.
REQ-034 Reset mid-byte (bit 3) -> next cycle A=1, B=1, busy=0; a new enable replays the full start pattern.
REQ-035 enable held high throughout a frame -> exactly one frame per IDLE visit; a new START 1 cycle after return to IDLE.
